// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and width helpers for the commit trace unit
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } trace_state_e;

    function automatic int lane_w(input int commit_width);
        return (commit_width > 1) ? $clog2(commit_width) : 1;
    endfunction

    function automatic int entry_w(input int cyc_w, input int commit_width, input int tag_w);
        return cyc_w + lane_w(commit_width) + tag_w;
    endfunction

endpackage

// File: rtl/trace_fifo_mp.sv
// rtl/trace_fifo_mp.sv - circular buffer with up to WR_N writes and one read per cycle
module trace_fifo_mp #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 16,
    parameter int WR_N  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(DEPTH):0]     wr_num,
    input  logic [WR_N*WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;

    assign pop      = rd_en && (count != '0);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    // wr_num is already limited to the free space by the caller
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_N; i++) begin
            if (CNT_W'(i) < wr_num) begin
                mem[wr_ptr + PTR_W'(i)] <= wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_num);
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + wr_num - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/commit_trace_unit.sv
// rtl/commit_trace_unit.sv - stamps ROB commits into a trace FIFO and tracks program completion
module commit_trace_unit
    import trace_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int TAG_W        = 5,
    parameter int PC_W         = 9,
    parameter int DEPTH        = 16,
    parameter int CYC_W        = 16,
    parameter int DRAIN_CYCLES = 50,
    parameter int MAX_CYCLES   = 10000
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PC_W-1:0]                               fetch_pc,
    input  logic [COMMIT_WIDTH-1:0]                       commit_valid,
    input  logic [COMMIT_WIDTH*TAG_W-1:0]                 commit_tag,
    output logic                                          trace_valid,
    input  logic                                          trace_ready,
    output logic [entry_w(CYC_W,COMMIT_WIDTH,TAG_W)-1:0]  trace_data,
    output logic                                          done,
    output logic                                          timeout,
    output logic [31:0]                                   commit_count,
    output logic [15:0]                                   drop_count,
    output logic [2:0]                                    state_o
);
    localparam int LANE_W  = lane_w(COMMIT_WIDTH);
    localparam int ENTRY_W = entry_w(CYC_W, COMMIT_WIDTH, TAG_W);
    localparam int FLAT_W  = COMMIT_WIDTH * ENTRY_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [CYC_W-1:0]  stamp;
        logic [LANE_W-1:0] lane;
        logic [TAG_W-1:0]  tag;
    } trace_entry_t;

    trace_state_e      state;
    logic [31:0]       phase;
    logic [CYC_W-1:0]  stamp;
    logic [PC_W-1:0]   prev_pc;

    logic              recording;
    trace_entry_t      lane_entry;
    logic [FLAT_W-1:0] packed_flat;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free;
    logic [CNT_W-1:0]  n_valid;
    logic [CNT_W-1:0]  written;
    logic [CNT_W-1:0]  dropped;
    logic [32:0]       commit_sum;
    logic [16:0]       drop_sum;

    // Valid lanes are compacted toward slot 0 so the FIFO writes a contiguous run
    always_comb begin
        int n;
        n           = 0;
        recording   = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DRAIN);
        packed_flat = '0;
        lane_entry  = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (recording && commit_valid[i]) begin
                lane_entry.stamp = stamp;
                lane_entry.lane  = LANE_W'(i);
                lane_entry.tag   = commit_tag[i*TAG_W +: TAG_W];
                packed_flat      = packed_flat | (FLAT_W'(lane_entry) << (n * ENTRY_W));
                n                = n + 1;
            end
        end
        n_valid    = CNT_W'(n);
        free       = CNT_W'(DEPTH) - count;
        written    = (n_valid < free) ? n_valid : free;
        dropped    = n_valid - written;
        commit_sum = {1'b0, commit_count} + 33'(written);
        drop_sum   = {1'b0, drop_count} + 17'(dropped);
    end

    trace_fifo_mp #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .WR_N  (COMMIT_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_num   (written),
        .wr_data  (packed_flat),
        .rd_en    (trace_ready),
        .rd_valid (trace_valid),
        .rd_data  (trace_data),
        .count    (count)
    );

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase        <= '0;
            stamp        <= '0;
            prev_pc      <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            commit_count <= '0;
            drop_count   <= '0;
        end else begin
            stamp        <= stamp + 1'b1;
            prev_pc      <= fetch_pc;
            commit_count <= commit_sum[32] ? 32'hFFFF_FFFF : commit_sum[31:0];
            drop_count   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            phase        <= phase + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fetch_pc != '0) begin
                        state <= ST_RUN;
                        phase <= '0;
                    end else if (phase == 32'(MAX_CYCLES - 1)) begin
                        state   <= ST_TIMEOUT;
                        phase   <= '0;
                        timeout <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fetch_pc == '0 && prev_pc != '0) begin
                        state <= ST_DRAIN;
                        phase <= '0;
                    end else if (phase == 32'(MAX_CYCLES - 1)) begin
                        state   <= ST_TIMEOUT;
                        phase   <= '0;
                        timeout <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (phase == 32'(DRAIN_CYCLES - 1)) begin
                        state <= ST_DONE;
                        phase <= '0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    phase <= phase;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_unit.sv
// tb/tb_commit_trace_unit.sv - directed self-checking bench for commit_trace_unit
module tb_commit_trace_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  fetch_pc = '0;
    logic [1:0]  commit_valid = '0;
    logic [9:0]  commit_tag = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [21:0] trace_data;
    logic        done;
    logic        timeout;
    logic [31:0] commit_count;
    logic [15:0] drop_count;
    logic [2:0]  state_o;

    int checks = 0;
    int failures = 0;

    commit_trace_unit #(
        .COMMIT_WIDTH (2),
        .TAG_W        (5),
        .PC_W         (9),
        .DEPTH        (16),
        .CYC_W        (16),
        .DRAIN_CYCLES (50),
        .MAX_CYCLES   (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_pc     (fetch_pc),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_data   (trace_data),
        .done         (done),
        .timeout      (timeout),
        .commit_count (commit_count),
        .drop_count   (drop_count),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        fetch_pc     = '0;
        commit_valid = '0;
        commit_tag   = '0;
        trace_ready  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [21:0] ent(input int s, input int l, input int t);
        return {16'(s), 1'(l), 5'(t)};
    endfunction

    initial begin
        // timeout with fetch_pc parked at zero
        do_reset();
        check_eq("rst_valid", 64'(trace_valid), 64'd0);
        check_eq("rst_commit", 64'(commit_count), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_timeout", 64'(timeout), 64'd0);
        check_eq("rst_state", 64'(state_o), 64'd0);
        step(99);
        check_eq("to_state99", 64'(state_o), 64'd0);
        check_eq("to_flag99", 64'(timeout), 64'd0);
        step();
        check_eq("to_state100", 64'(state_o), 64'd4);
        check_eq("to_flag100", 64'(timeout), 64'd1);
        check_eq("to_done", 64'(done), 64'd0);
        commit_valid = 2'b11;
        step();
        commit_valid = 2'b00;
        check_eq("to_ign_commit", 64'(commit_count), 64'd0);
        check_eq("to_ign_drop", 64'(drop_count), 64'd0);
        check_eq("to_ign_valid", 64'(trace_valid), 64'd0);

        // completion: 0 -> 4 -> 8 -> 0, then drain
        do_reset();
        fetch_pc = 9'd4;
        step();
        check_eq("run_state", 64'(state_o), 64'd1);
        fetch_pc = 9'd8;
        step();
        fetch_pc = 9'd0;
        step();
        check_eq("drain_enter", 64'(state_o), 64'd2);
        fetch_pc = 9'd5;
        step(49);
        check_eq("drain_state49", 64'(state_o), 64'd2);
        check_eq("drain_done49", 64'(done), 64'd0);
        step();
        check_eq("done_state", 64'(state_o), 64'd3);
        check_eq("done_flag", 64'(done), 64'd1);
        fetch_pc = 9'd0;
        step(3);
        check_eq("done_sticky_state", 64'(state_o), 64'd3);
        check_eq("done_sticky_flag", 64'(done), 64'd1);
        check_eq("done_no_timeout", 64'(timeout), 64'd0);

        // two lanes at stamp 5
        do_reset();
        fetch_pc    = 9'd4;
        trace_ready = 1'b1;
        step(5);
        commit_valid = 2'b11;
        commit_tag   = {5'd7, 5'd3};
        step();
        commit_valid = 2'b00;
        check_eq("pair_valid0", 64'(trace_valid), 64'd1);
        check_eq("pair_data0", 64'(trace_data), 64'(ent(5, 0, 3)));
        check_eq("pair_commit", 64'(commit_count), 64'd2);
        step();
        check_eq("pair_data1", 64'(trace_data), 64'(ent(5, 1, 7)));
        step();
        check_eq("pair_empty", 64'(trace_valid), 64'd0);

        // fill to full with ready low: 9 cycles of 2-lane commits
        do_reset();
        fetch_pc = 9'd4;
        for (int k = 0; k < 9; k++) begin
            commit_valid = 2'b11;
            commit_tag   = {5'(2*k+1), 5'(2*k)};
            step();
        end
        check_eq("full_commit", 64'(commit_count), 64'd16);
        check_eq("full_drop", 64'(drop_count), 64'd2);
        check_eq("full_head", 64'(trace_data), 64'(ent(0, 0, 0)));
        // full FIFO: pop credited only next cycle, both lanes dropped
        trace_ready = 1'b1;
        commit_tag  = {5'd21, 5'd20};
        step();
        check_eq("fullpop_commit", 64'(commit_count), 64'd16);
        check_eq("fullpop_drop", 64'(drop_count), 64'd4);
        check_eq("fullpop_head", 64'(trace_data), 64'(ent(0, 1, 1)));
        // one slot free: lane 0 written, lane 1 dropped
        trace_ready = 1'b0;
        commit_tag  = {5'd31, 5'd30};
        step();
        commit_valid = 2'b00;
        check_eq("onefree_commit", 64'(commit_count), 64'd17);
        check_eq("onefree_drop", 64'(drop_count), 64'd5);
        check_eq("stall_stable", 64'(trace_data), 64'(ent(0, 1, 1)));
        trace_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check_eq($sformatf("drain_v%0d", j), 64'(trace_valid), 64'd1);
            if (j < 15)
                check_eq($sformatf("drain_d%0d", j), 64'(trace_data), 64'(ent((j+1)/2, (j+1)%2, j+1)));
            else
                check_eq("drain_last", 64'(trace_data), 64'(ent(10, 0, 30)));
            step();
        end
        check_eq("drain_empty", 64'(trace_valid), 64'd0);

        // reset with 5 entries queued
        do_reset();
        fetch_pc     = 9'd4;
        commit_valid = 2'b11;
        step();
        step();
        commit_valid = 2'b01;
        step();
        commit_valid = 2'b00;
        check_eq("pre_rst_valid", 64'(trace_valid), 64'd1);
        check_eq("pre_rst_commit", 64'(commit_count), 64'd5);
        check_eq("pre_rst_state", 64'(state_o), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("post_rst_valid", 64'(trace_valid), 64'd0);
        check_eq("post_rst_commit", 64'(commit_count), 64'd0);
        check_eq("post_rst_drop", 64'(drop_count), 64'd0);
        check_eq("post_rst_state", 64'(state_o), 64'd0);
        commit_valid = 2'b01;
        commit_tag   = {5'd0, 5'd9};
        step();
        commit_valid = 2'b00;
        check_eq("post_rst_stamp", 64'(trace_data), 64'(ent(0, 0, 9)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
